// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the five-stage pipeline.
// It merges per-stage stall requests and runs the multi-cycle divide
// sequencer. It also runs the exception/ERET redirect sequencer, which holds
// off a PC redirect while an instruction-bus read is still outstanding.
// Optional feature macro: PIPE_STALL_CNT_EN adds stall/flush event counters.
module pipeline_ctrl #(
  parameter int unsigned DIV_LAT   = 32,
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_mem,
  input  logic        div_start,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] cp0_epc,
  input  logic        if_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] flush_pc,
  output logic        div_busy,
  output logic        div_done
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cnt
`endif
);

  // Counter only has to hold DIV_LAT-1, so log2(DIV_LAT) bits are enough.
  localparam int unsigned CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 1);

  // Stall vector patterns; a set bit freezes that stage (0 PC .. 5 WB).
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

  typedef enum logic {
    E_RUN   = 1'b0,
    E_DRAIN = 1'b1
  } exc_state_t;

  div_state_t    div_state, div_state_next;
  logic [CW-1:0] div_cnt, div_cnt_next;
  exc_state_t    exc_state, exc_state_next;
  logic [31:0]   drain_pc, drain_pc_next;

  logic [31:0]   exc_target;
  logic          exc_take;
  logic          flush_raw;
  logic          redirect_raw;
  logic [31:0]   pc_raw;
  logic [5:0]    stall_raw;

  // An exception or ERET is accepted only in E_RUN; in E_DRAIN it is ignored.
  assign exc_take   = (exc_state == E_RUN) && exc_valid;
  assign exc_target = exc_eret ? cp0_epc : EXC_ENTRY;

  // Exception sequencer: flush immediately, redirect once the I-bus is idle.
  always_comb begin
    exc_state_next = exc_state;
    drain_pc_next  = drain_pc;
    flush_raw      = 1'b0;
    redirect_raw   = 1'b0;
    pc_raw         = 32'h0;
    case (exc_state)
      E_RUN: begin
        if (exc_valid) begin
          flush_raw = 1'b1;
          if (!if_busy) begin
            redirect_raw = 1'b1;
            pc_raw       = exc_target;
          end else begin
            drain_pc_next  = exc_target;
            exc_state_next = E_DRAIN;
          end
        end
      end
      E_DRAIN: begin
        flush_raw = 1'b1;
        if (!if_busy) begin
          redirect_raw   = 1'b1;
          pc_raw         = drain_pc;
          drain_pc_next  = 32'h0;
          exc_state_next = E_RUN;
        end
      end
      default: begin
        exc_state_next = E_RUN;
        drain_pc_next  = 32'h0;
      end
    endcase
  end

  // Divide sequencer: a flush aborts it outright and suppresses div_done.
  always_comb begin
    div_state_next = div_state;
    div_cnt_next   = div_cnt;
    if (flush_raw) begin
      div_state_next = D_IDLE;
      div_cnt_next   = '0;
    end else begin
      case (div_state)
        D_IDLE: begin
          if (div_start) begin
            div_state_next = D_BUSY;
            div_cnt_next   = CNT_LOAD;
          end
        end
        D_BUSY: begin
          if (div_cnt == '0) begin
            div_state_next = D_DONE;
          end else begin
            div_cnt_next = div_cnt - CW'(1);
          end
        end
        D_DONE: begin
          // A still-high div_start here belongs to the finished divide.
          div_state_next = D_IDLE;
        end
        default: begin
          div_state_next = D_IDLE;
          div_cnt_next   = '0;
        end
      endcase
    end
  end

  // Stall merge: draining holds PC/IF, flush beats all, else deepest wins.
  always_comb begin
    stall_raw = STALL_NONE;
    if (exc_state == E_DRAIN) begin
      stall_raw = STALL_IF;
    end else if (flush_raw) begin
      stall_raw = STALL_NONE;
    end else if (stallreq_mem) begin
      stall_raw = STALL_MEM;
    end else if (div_state == D_BUSY) begin
      stall_raw = STALL_DIV;
    end else if (stallreq_id) begin
      stall_raw = STALL_ID;
    end else if (stallreq_if) begin
      stall_raw = STALL_IF;
    end
  end

  // State registers for both sequencers and the latched redirect target.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      div_state <= D_IDLE;
      div_cnt   <= '0;
      exc_state <= E_RUN;
      drain_pc  <= 32'h0;
    end else begin
      div_state <= div_state_next;
      div_cnt   <= div_cnt_next;
      exc_state <= exc_state_next;
      drain_pc  <= drain_pc_next;
    end
  end

  // Combinational outputs are forced low while reset is held so that
  // consumers see a quiet controller regardless of the input levels.
  assign stall    = cpu_rst_n ? stall_raw    : STALL_NONE;
  assign flush    = cpu_rst_n ? flush_raw    : 1'b0;
  assign redirect = cpu_rst_n ? redirect_raw : 1'b0;
  assign flush_pc = cpu_rst_n ? pc_raw       : 32'h0;

  assign div_busy = (div_state == D_BUSY);
  assign div_done = (div_state == D_DONE);

`ifdef PIPE_STALL_CNT_EN
  // Performance counters: stalled cycles and accepted exceptions, wrapping.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cycles <= 32'h0;
      flush_cnt    <= 32'h0;
    end else begin
      if (stall_raw != STALL_NONE) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (exc_take) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  // Without the counters exc_take only documents the acceptance condition.
  logic unused_take;
  assign unused_take = exc_take;
`endif

endmodule
